// File: rtl/fpu_pkg.sv
// Shared FPU constants and the float-to-int classification used by ftoi_pipe.
package fpu_pkg;
    localparam int               EXP_W     = 8;
    localparam int               MAN_W     = 23;
    localparam logic [EXP_W-1:0] BIAS      = 8'd127;
    localparam logic [31:0]      INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0]      INT32_MIN = 32'h8000_0000;
    localparam logic [31:0]      FLOOR_OVF = 32'h8000_0000;

    typedef enum logic [2:0] {ZERO, NORM, BIG, INF, NAN, SENT} ftoi_class_t;
endpackage

// File: rtl/ftoi_align.sv
// Shifts a 24-bit significand into an int32 magnitude, applies sign, and
// reports whether any fraction bits were discarded (truncation toward zero).
module ftoi_align (
    input  logic [23:0] i_sig,
    input  logic [4:0]  i_sh,
    input  logic        i_sign,
    output logic [31:0] o_data,
    output logic        o_inexact
);
    logic [4:0]  w_lsh;
    logic [4:0]  w_rsh;
    logic [23:0] w_mask;
    logic [30:0] w_mag;

    always_comb begin
        w_lsh     = i_sh - 5'd23;
        w_rsh     = 5'd23 - i_sh;
        w_mask    = '0;
        w_mag     = '0;
        o_inexact = 1'b0;
        if (i_sh >= 5'd23) begin
            w_mag = {7'd0, i_sig} << w_lsh;
        end else begin
            w_mag     = {7'd0, i_sig >> w_rsh};
            w_mask    = (24'd1 << w_rsh) - 24'd1;
            o_inexact = |(i_sig & w_mask);
        end
        o_data = i_sign ? -{1'b0, w_mag} : {1'b0, w_mag};
    end
endmodule

// File: rtl/ftoi_pipe.sv
// Two-stage float-to-int32 converter (truncate toward zero, saturating) with
// valid/ready on both sides; stage 1 classifies, stage 2 aligns and saturates.
module ftoi_pipe
    import fpu_pkg::*;
#(
    parameter bit FLOOR_SENTINEL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_ovf,
    output logic        out_inexact
);
    logic              w_s1_adv;
    logic              w_s2_adv;
    logic [EXP_W-1:0]  w_exp;
    logic [MAN_W-1:0]  w_man;
    logic [EXP_W-1:0]  w_e;
    ftoi_class_t       w_cls;

    logic              r_vld_p1;
    logic              r_sign_p1;
    ftoi_class_t       r_cls_p1;
    logic [23:0]       r_sig_p1;
    logic [4:0]        r_sh_p1;
    logic              r_zinx_p1;
    logic              r_negmin_p1;

    logic [31:0]       w_al_data;
    logic              w_al_inx;
    logic [31:0]       w_data;
    logic              w_ovf;
    logic              w_inx;

    logic              r_vld_p2;
    logic [31:0]       r_data_p2;
    logic              r_ovf_p2;
    logic              r_inx_p2;

    function automatic logic [31:0] sat_word(input logic neg);
        return neg ? INT32_MIN : INT32_MAX;
    endfunction

    assign w_s2_adv  = !r_vld_p2 || out_ready;
    assign w_s1_adv  = !r_vld_p1 || w_s2_adv;
    assign in_ready  = w_s1_adv;
    assign out_valid = r_vld_p2;

    // ---- stage 1: classify ----
    assign w_exp = in_data[MAN_W +: EXP_W];
    assign w_man = in_data[MAN_W-1:0];
    assign w_e   = w_exp - BIAS;

    always_comb begin
        w_cls = NORM;
        if (FLOOR_SENTINEL && (in_data == FLOOR_OVF))
            w_cls = SENT;
        else if (w_exp == '1)
            w_cls = (w_man == '0) ? INF : NAN;
        else if (w_exp < BIAS)
            w_cls = ZERO;
        else if (w_e >= 8'd31)
            w_cls = BIG;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_vld_p1 <= 1'b0;
        else if (w_s1_adv)
            r_vld_p1 <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (w_s1_adv && in_valid) begin
            r_sign_p1   <= in_data[31];
            r_cls_p1    <= w_cls;
            r_sig_p1    <= {1'b1, w_man};
            r_sh_p1     <= w_e[4:0];
            r_zinx_p1   <= |in_data[30:0];
            // exactly -2^31 is the one BIG value that fits without saturating
            r_negmin_p1 <= (in_data == 32'hCF00_0000);
        end
    end

    // ---- stage 2: align and saturate ----
    ftoi_align u_align (
        .i_sig     (r_sig_p1),
        .i_sh      (r_sh_p1),
        .i_sign    (r_sign_p1),
        .o_data    (w_al_data),
        .o_inexact (w_al_inx)
    );

    always_comb begin
        w_data = INT32_MAX;
        w_ovf  = 1'b1;
        w_inx  = 1'b0;
        case (r_cls_p1)
            ZERO: begin
                w_data = '0;
                w_ovf  = 1'b0;
                w_inx  = r_zinx_p1;
            end
            NORM: begin
                w_data = w_al_data;
                w_ovf  = 1'b0;
                w_inx  = w_al_inx;
            end
            BIG: begin
                w_data = sat_word(r_sign_p1);
                w_ovf  = !r_negmin_p1;
            end
            INF:     w_data = sat_word(r_sign_p1);
            NAN:     w_data = INT32_MAX;
            SENT:    w_data = INT32_MIN;
            default: w_data = INT32_MAX;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_p2  <= 1'b0;
            r_data_p2 <= '0;
            r_ovf_p2  <= 1'b0;
            r_inx_p2  <= 1'b0;
        end else if (w_s2_adv) begin
            r_vld_p2 <= r_vld_p1;
            if (r_vld_p1) begin
                r_data_p2 <= w_data;
                r_ovf_p2  <= w_ovf;
                r_inx_p2  <= w_inx;
            end
        end
    end

    assign out_data    = r_data_p2;
    assign out_ovf     = r_ovf_p2;
    assign out_inexact = r_inx_p2;
endmodule

// File: tb/tb_ftoi_pipe.sv
// Bench for ftoi_pipe: directed vectors plus random traffic against a
// real-arithmetic reference model, with random handshake stalls.
module tb_ftoi_pipe;
    localparam bit SENT = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_ovf;
    logic        out_inexact;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [31:0] acc_q[$];
    int          acc_cyc_q[$];
    logic [33:0] got_q[$];
    int          got_cyc_q[$];

    ftoi_pipe #(.FLOOR_SENTINEL(SENT)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_ovf     (out_ovf),
        .out_inexact (out_inexact)
    );

    always #5 clk = ~clk;

    // Reference: {data[31:0], ovf, inexact} from the real value, truncated toward zero.
    function automatic logic [33:0] ref_model(input logic [31:0] b);
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        logic [63:0] db;
        real         v;
        int          r;
        s = b[31];
        e = b[30:23];
        m = b[22:0];
        if (e == 8'hFF)
            return {((m != 0) || !s) ? 32'h7FFF_FFFF : 32'h8000_0000, 2'b10};
        if (SENT && b == 32'h8000_0000)
            return {32'h8000_0000, 2'b10};
        if (e == 8'h00)
            return {32'd0, 1'b0, (m != 0)};
        db = {s, 11'(e) + 11'd896, m, 29'd0};
        v  = $bitstoreal(db);
        if (v >= 2147483648.0)
            return {32'h7FFF_FFFF, 2'b10};
        if (v < -2147483648.0)
            return {32'h8000_0000, 2'b10};
        r = $rtoi(v);
        return {r, 1'b0, (real'(r) != v)};
    endfunction

    // One cycle: drive at negedge, note which handshakes will fire at the next posedge.
    task automatic step(input logic v, input logic [31:0] d, input logic ordy);
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        #1;
        if (in_valid && in_ready) begin
            acc_q.push_back(d);
            acc_cyc_q.push_back(cyc);
        end
        if (out_valid && out_ready) begin
            got_q.push_back({out_data, out_ovf, out_inexact});
            got_cyc_q.push_back(cyc);
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) step(1'b0, $urandom(), 1'b1);
    endtask

    task automatic clear_q();
        acc_q.delete();
        acc_cyc_q.delete();
        got_q.delete();
        got_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if ({out_ovf, out_inexact} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {out_ovf, out_inexact}); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
        @(negedge clk);
    endtask

    task automatic test_stream();
        logic [31:0] vin[5]  = '{32'h4040_0000, 32'hC040_0000, 32'h4049_0000, 32'h3F00_0000, 32'hBF00_0000};
        logic [33:0] vexp[5] = '{{32'd3, 2'b00}, {32'hFFFF_FFFD, 2'b00}, {32'd3, 2'b01},
                                 {32'd0, 2'b01}, {32'd0, 2'b01}};
        clear_q();
        for (int i = 0; i < 5; i++) step(1'b1, vin[i], 1'b1);
        drain(5);
        n_cmp++; if (got_q.size() != 5 || acc_q.size() != 5) begin n_fail++; $display("FAIL stream_count: got %0d/%0d want 5/5", acc_q.size(), got_q.size()); end
        for (int i = 0; i < 5 && i < got_q.size() && i < acc_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== vexp[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h want %h", i, got_q[i], vexp[i]); end
            n_cmp++; if (got_cyc_q[i] - acc_cyc_q[i] != 2) begin n_fail++; $display("FAIL stream_latency[%0d]: got %0d want 2", i, got_cyc_q[i] - acc_cyc_q[i]); end
            n_cmp++; if (acc_cyc_q[i] != acc_cyc_q[0] + i) begin n_fail++; $display("FAIL stream_b2b[%0d]: accept cycle %0d want %0d", i, acc_cyc_q[i], acc_cyc_q[0] + i); end
        end
    endtask

    task automatic test_special();
        logic [31:0] vin[9]  = '{32'h4F00_0000, 32'hCF00_0000, 32'hCF00_0001, 32'h4EFF_FFFF,
                                 32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h8000_0000, 32'h0000_0001};
        logic [33:0] vexp[9] = '{{32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b00}, {32'h8000_0000, 2'b10},
                                 {32'h7FFF_FF80, 2'b00}, {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b10},
                                 {32'h7FFF_FFFF, 2'b10}, {32'h8000_0000, 2'b10}, {32'd0, 2'b01}};
        if (!SENT) vexp[7] = {32'd0, 2'b00};
        clear_q();
        for (int i = 0; i < 9; i++) step(1'b1, vin[i], 1'b1);
        drain(5);
        n_cmp++; if (got_q.size() != 9) begin n_fail++; $display("FAIL special_count: got %0d want 9", got_q.size()); end
        for (int i = 0; i < 9 && i < got_q.size(); i++) begin
            n_cmp++; if (got_q[i] !== vexp[i]) begin n_fail++; $display("FAIL special[%h]: got %h want %h", vin[i], got_q[i], vexp[i]); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] bp[4] = '{32'h4120_0000, 32'hC1A0_0000, 32'h42F6_0000, 32'h3FC0_0000};
        logic [33:0] want;
        logic [31:0] hold;
        int idx = 0;
        int guard = 0;
        clear_q();
        hold = '0;
        for (int c = 0; c < 6; c++) begin
            step(1'b1, bp[idx], 1'b0);
            if (acc_q.size() > idx) idx++;
            if (c == 2) hold = out_data;
        end
        n_cmp++; if (idx != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d want 2", idx); end
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %0b want 0", in_ready); end
        n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %0b want 1", out_valid); end
        want = ref_model(bp[0]);
        n_cmp++; if (out_data !== want[33:2] || out_data !== hold) begin n_fail++; $display("FAIL bp_hold: got %h (earlier %h) want %h", out_data, hold, want[33:2]); end
        while (idx < 4 && guard < 20) begin
            step(1'b1, bp[idx], 1'b1);
            if (acc_q.size() > idx) idx++;
            guard++;
        end
        drain(5);
        n_cmp++; if (got_q.size() != 4) begin n_fail++; $display("FAIL bp_count: got %0d want 4", got_q.size()); end
        for (int i = 0; i < 4 && i < got_q.size(); i++) begin
            want = ref_model(bp[i]);
            n_cmp++; if (got_q[i] !== want) begin n_fail++; $display("FAIL bp_order[%0d]: got %h want %h", i, got_q[i], want); end
        end
    endtask

    task automatic test_reset_midflight();
        logic [33:0] want;
        clear_q();
        step(1'b1, 32'h4100_0000, 1'b0);
        step(1'b1, 32'hC100_0000, 1'b0);
        rst = 1'b1;
        step(1'b0, 32'h0, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_out_valid: got %0b want 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %0b want 1", in_ready); end
        n_cmp++; if (out_data !== 32'd0) begin n_fail++; $display("FAIL rstmid_out_data: got %h want 0", out_data); end
        clear_q();
        step(1'b1, 32'h4160_0000, 1'b1);
        drain(5);
        want = {32'd14, 2'b00};
        n_cmp++; if (got_q.size() != 1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", got_q.size()); end
        if (got_q.size() >= 1) begin
            n_cmp++; if (got_q[0] !== want) begin n_fail++; $display("FAIL rstmid_data: got %h want %h", got_q[0], want); end
            n_cmp++; if (got_cyc_q[0] - acc_cyc_q[0] != 2) begin n_fail++; $display("FAIL rstmid_latency: got %0d want 2", got_cyc_q[0] - acc_cyc_q[0]); end
        end
    endtask

    function automatic logic [31:0] gen_float();
        logic [31:0] w;
        case ($urandom_range(0, 3))
            0: w = $urandom();
            1: w = {1'($urandom()), 8'($urandom_range(118, 166)), 23'($urandom())};
            2: case ($urandom_range(0, 5))
                   0: w = 32'h8000_0000;
                   1: w = 32'hCF00_0000;
                   2: w = {1'($urandom()), 8'hFF, 23'($urandom_range(0, 1))};
                   3: w = {1'($urandom()), 8'h00, 23'($urandom())};
                   4: w = {1'($urandom()), 8'd158, 23'($urandom_range(0, 2))};
                   default: w = {1'($urandom()), 8'd127, 23'd0};
               endcase
            default: w = {1'($urandom()), 8'($urandom_range(145, 159)), ($urandom_range(0, 1) != 0) ? 23'($urandom()) : 23'd0};
        endcase
        return w;
    endfunction

    task automatic test_random();
        logic [31:0] cur;
        logic [33:0] want;
        logic        v;
        int sent = 0;
        int cycles = 0;
        clear_q();
        cur = gen_float();
        while (sent < 10000 && cycles < 40000) begin
            v = ($urandom_range(0, 3) != 0);
            step(v, v ? cur : $urandom(), ($urandom_range(0, 3) != 0));
            if (acc_q.size() > sent) begin
                sent++;
                cur = gen_float();
            end
            cycles++;
        end
        drain(6);
        n_cmp++; if (acc_q.size() != 10000) begin n_fail++; $display("FAIL rand_sent: got %0d want 10000", acc_q.size()); end
        n_cmp++; if (got_q.size() != acc_q.size()) begin n_fail++; $display("FAIL rand_count: got %0d want %0d", got_q.size(), acc_q.size()); end
        for (int i = 0; i < got_q.size() && i < acc_q.size(); i++) begin
            want = ref_model(acc_q[i]);
            n_cmp++;
            if (got_q[i] !== want || got_q[i][1:0] == 2'b11) begin
                n_fail++;
                $display("FAIL rand[%0d] in=%h: got %h want %h", i, acc_q[i], got_q[i], want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_special();
        test_backpressure();
        test_reset_midflight();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/ftoi_pipe.md
Name: ftoi_pipe

Overview:
Pipelined float-to-signed-int32 converter that consumes the output of the combinational floor unit (IEEE-754 single, already rounded toward -inf). Produces an int32 with truncation toward zero, saturation, and overflow/inexact flags. Two register stages with valid/ready handshakes on both sides, so it sits between floor and the FPU writeback/result mux and can absorb backpressure.

Parameters:
- FLOOR_SENTINEL, 1, when 1 the input 0x80000000 is treated as floor's overflow marker (result INT_MIN, ovf=1); when 0 it is -0.0 (result 0, no flags)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data this cycle
- in_data  in  32  IEEE-754 single (sign[31], exp[30:23], man[22:0])
- out_valid  out  1  out_* valid
- out_ready  in  1  consumer accepts this cycle
- out_data  out  32  two's-complement int32 result
- out_ovf  out  1  saturated, NaN, inf, or sentinel
- out_inexact  out  1  nonzero fraction bits discarded

Behaviour:
- Reset (sync, rst=1 at posedge): s1_valid=0, s2_valid=0; out_valid=0, out_data=0, out_ovf=0, out_inexact=0. Reset overrides any simultaneous handshake; in-flight data is dropped, and no stale beat appears after reset.
- Transfer occurs on a side when valid&&ready at posedge. Latency is exactly 2 cycles from input transfer to out_valid when unstalled. Throughput is 1 per cycle.
- Control:
  - s2_adv = !s2_valid || out_ready.
  - s1_adv = !s1_valid || s2_adv.
  - in_ready = s1_adv (combinational from out_ready, by design).
  - out_valid = s2_valid.
  - Data registers load only on advance and hold otherwise.
  - out_* are stable while out_valid && !out_ready.
- Stage 1 (classify, registered):
  - E = exp - 127.
  - Classes:
    - ZERO: exp<127, which includes denormals and zero.
    - NORM: 0<=E<=30.
    - BIG: E>=31, exp!=255.
    - INF: exp=255, man=0.
    - NAN: exp=255, man!=0.
    - SENT: in_data=0x80000000 with FLOOR_SENTINEL=1.
  - Latch sign, class, 24-bit significand {1,man}, and 5-bit shift amount E.
- Stage 2 (align, registered):
  - NORM with E>=23: mag = sig << (E-23) in 31 bits, inexact=0.
  - NORM with E<23: mag = sig >> (23-E), inexact = |(sig & ((1<<(23-E))-1)).
  - Result is sign ? -mag : mag in 32 bits.
  - ZERO: result 0; inexact=1 iff exp!=0 or man!=0; ovf=0.
  - BIG: positive gives 0x7FFFFFFF with ovf=1. Negative gives 0x80000000 with ovf=0 iff in_data==0xCF000000 (exactly -2^31), else ovf=1.
  - INF: +inf gives 0x7FFFFFFF, -inf gives 0x80000000; ovf=1 in both cases.
  - NAN: 0x7FFFFFFF, ovf=1, inexact=0.
  - SENT: 0x80000000, ovf=1.
  - ovf and inexact are never both 1.
- Boundaries:
  - s2 full with out_ready=0 and s1 full: in_ready=0, and nothing is overwritten.
  - out_ready=1 while s2, s1 and input are all valid: all three advance in the same cycle.
  - Input data is ignored while in_valid=0; stage valids clear when stages drain.

Decomposition:
- Shared package fpu_pkg holds:
  - widths EXP_W=8, MAN_W=23
  - BIAS=127
  - INT32_MAX/INT32_MIN
  - FLOOR_OVF=32'h80000000
  - enum ftoi_class_t {ZERO, NORM, BIG, INF, NAN, SENT}
- One combinational sub-module, ftoi_align: takes sig[23:0], sh[4:0] and sign, and returns data[31:0] and inexact. It is instantiated in stage 2 and unit-testable standalone.

Test Plan:
- Stream 0x40400000, 0xC0400000, 0x40490000, 0x3F000000, 0xBF000000 with out_ready=1 → outputs 3, 0xFFFFFFFD, 3 (inexact=1), 0 (inexact=1), 0 (inexact=1), each 2 cycles after its accept, back-to-back.
- Saturation inputs:
  - 0x4F000000 → 0x7FFFFFFF, ovf=1.
  - 0xCF000000 → 0x80000000, ovf=0.
  - 0xCF000001 → 0x80000000, ovf=1.
  - 0x4EFFFFFF → 0x7FFFFF80, flags 0.
- Specials:
  - 0x7F800000 → 0x7FFFFFFF, ovf=1.
  - 0xFF800000 → 0x80000000, ovf=1.
  - 0x7FC00000 → 0x7FFFFFFF, ovf=1.
  - 0x80000000 → 0x80000000, ovf=1 (FLOOR_SENTINEL=1) or 0, no flags (FLOOR_SENTINEL=0).
  - 0x00000001 → 0, inexact=1.
- Backpressure: drive 4 inputs continuously with out_ready=0 → exactly 2 accepted, then in_ready=0 and out_data held stable. Release out_ready → all 4 emerge in order with no duplicates.
- Reset mid-flight: assert rst one cycle while s1 and s2 hold data → next cycle out_valid=0, in_ready=1, out_data=0. A new input after reset appears 2 cycles later, unaffected.
- Random 10k vectors vs. a golden truncating reference model, with random in_valid/out_ready toggling → bit-exact data and flags, order preserved, no beat lost or duplicated.
